// File: rtl/sr04_pkg.sv
// Shared state type, constants and echo-width helper for the HC-SR04 echo responder.
// The HOLDOFF state only exists when SR04_ECHO_HOLDOFF_EN is defined.
package sr04_pkg;

    localparam int CNT_W       = 16;
    localparam int DIST_W      = 9;
    localparam int US_PER_CM   = 58;
    localparam int MIN_DIST_CM = 2;
    localparam int MAX_DIST_CM = 400;

`ifdef SR04_ECHO_HOLDOFF_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_BURST,
        S_ECHO
    } state_e;
`endif

    // Out-of-range targets answer with the sensor's "no echo" timeout width.
    function automatic logic [CNT_W-1:0] echo_ticks(
        input logic [DIST_W-1:0] dist_cm,
        input logic [CNT_W-1:0]  timeout
    );
        if (dist_cm >= DIST_W'(MIN_DIST_CM) && dist_cm <= DIST_W'(MAX_DIST_CM))
            return CNT_W'(dist_cm) * CNT_W'(US_PER_CM);
        return timeout;
    endfunction

endpackage

// File: rtl/sr04_us_timer.sv
// Microsecond tick counter with synchronous clear and a terminal-count strobe,
// shared by every timed state of the echo responder.
module sr04_us_timer
    import sr04_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: default assigned first so no path leaves count_d unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (tick_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Fires on the tick that completes limit_i counts so the owner leaves on that edge.
    assign last_o  = tick_i && (count_q == limit_i - 1'b1);
    assign count_o = count_q;

endmodule

// File: rtl/sr04_echo_responder.sv
// HC-SR04 emulator: validates trigger width, waits the burst delay, then drives an
// echo proportional to distance. Define SR04_ECHO_HOLDOFF_EN for a post-echo holdoff.
module sr04_echo_responder
    import sr04_pkg::*;
#(
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 60000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick_1us,
    input  logic              i_trigger,
    input  logic [DIST_W-1:0] i_distance_cm,
    output logic              o_echo,
    output logic              o_busy,
    output logic              o_short_trig
);

    localparam logic [CNT_W-1:0] MIN_TRIG_C = CNT_W'(MIN_TRIG_US);
    localparam logic [CNT_W-1:0] BURST_C    = CNT_W'(BURST_US);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] HOLDOFF_C  = CNT_W'(HOLDOFF_US);

    state_e            state_q, state_d;
    logic              trig_q;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              echo_q, echo_d;
    logic              short_q, short_d;

    logic              tmr_clear, tmr_tick, tmr_last;
    logic [CNT_W-1:0]  tmr_count, tmr_limit;
    logic              trig_rise, trig_fall, trig_full;

    assign trig_rise = i_trigger && !trig_q;
    assign trig_fall = !i_trigger && trig_q;
    assign trig_full = (tmr_count >= MIN_TRIG_C);

    // Width measurement saturates; IDLE never counts.
    assign tmr_tick  = i_tick_1us && (state_q != S_IDLE) && !(state_q == S_TRIG && trig_full);
    assign tmr_clear = (state_d != state_q);

    always_comb begin
        tmr_limit = HOLDOFF_C;
        case (state_q)
            S_BURST: tmr_limit = BURST_C;
            S_ECHO:  tmr_limit = echo_ticks(dist_q, TIMEOUT_C);
            default: ;
        endcase
    end

    sr04_us_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tmr_clear),
        .tick_i  (tmr_tick),
        .limit_i (tmr_limit),
        .count_o (tmr_count),
        .last_o  (tmr_last)
    );

    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        short_d = 1'b0;
        case (state_q)
            S_IDLE: if (trig_rise) state_d = S_TRIG;
            S_TRIG: begin
                if (trig_fall) begin
                    if (trig_full) begin
                        state_d = S_BURST;
                        dist_d  = i_distance_cm;
                    end else begin
                        state_d = S_IDLE;
                        short_d = 1'b1;
                    end
                end
            end
            S_BURST: if (tmr_last) state_d = S_ECHO;
`ifdef SR04_ECHO_HOLDOFF_EN
            S_ECHO:    if (tmr_last) state_d = S_HOLDOFF;
            S_HOLDOFF: if (tmr_last) state_d = S_IDLE;
`else
            S_ECHO:    if (tmr_last) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        echo_d = (state_d == S_ECHO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b1;  // a trigger held through reset must not read as a fresh edge
            dist_q  <= '0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= i_trigger;
            dist_q  <= dist_d;
            echo_q  <= echo_d;
            short_q <= short_d;
        end
    end

    assign o_echo       = echo_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_short_trig = short_q;

endmodule

// File: doc/sr04_echo_responder.md
SR04_ECHO_RESPONDER -- requirements
Module: sr04_echo_responder

Interface
REQ-001 The block SHALL have these parameters: MIN_TRIG_US, 10, minimum accepted trigger high width in 1 us ticks.
REQ-002 BURST_US, 200, delay from trigger fall to echo rise, in ticks.
REQ-003 TIMEOUT_US, 38000, echo width for an out-of-range distance, in ticks.
REQ-004 HOLDOFF_US, 60000, minimum time from echo fall to the next accepted trigger (macro-gated).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port: clk  in  1  system clock; all logic on the rising edge.
REQ-007 Port: rst  in  1  synchronous, active-high reset.
REQ-008 Port: i_tick_1us  in  1  one-clk-wide strobe once per microsecond.
REQ-009 Port: i_trigger  in  1  trigger from the controller, synchronous to clk.
REQ-010 Port: i_distance_cm  in  9  emulated target distance in cm.
REQ-011 Port: o_echo  out  1  echo pulse to the controller.
REQ-012 Port: o_busy  out  1  high in every state except IDLE.
REQ-013 Port: o_short_trig  out  1  one-clk pulse when a trigger is rejected as too short.

Function
REQ-014 The block SHALL implement the states IDLE, TRIG, BURST, ECHO and HOLDOFF.
REQ-015 IDLE -> TRIG on a rising edge of i_trigger: registered previous value 0, current 1; a trigger already high on entry to IDLE SHALL NOT start a cycle.
REQ-016 TRIG: the width counter increments only on i_tick_1us and saturates at MIN_TRIG_US.
- On i_trigger falling with width >= MIN_TRIG_US -> BURST, latching i_distance_cm.
- Otherwise -> IDLE, with o_short_trig high for exactly one clk.
REQ-017 BURST: after BURST_US ticks -> ECHO; o_echo rises on the clk edge that consumes the BURST_US-th tick.
REQ-018 ECHO width SHALL be latched distance x 58 ticks when the distance is in 2..400, else TIMEOUT_US ticks.
- Product width is 16 bits unsigned; 400 x 58 = 23200 and 38000 both fit.
REQ-019 o_echo SHALL fall on the clk edge consuming the last echo tick; the FSM goes to HOLDOFF (macro on) or IDLE (macro off).
REQ-020 i_trigger edges during BURST, ECHO and HOLDOFF SHALL be ignored; i_distance_cm changes after latching SHALL have no effect.
REQ-021 A tick coinciding with a trigger edge SHALL count toward the state entered at that edge only from the next tick.
REQ-022 The tick counter SHALL reset to 0 on every state transition.

Reset
REQ-023 While rst is high, the FSM SHALL be IDLE, all counters 0, and o_echo, o_busy, o_short_trig 0.
REQ-024 rst asserted mid-operation, including mid-ECHO, SHALL drop o_echo on that same clk edge; no partial cycle resumes after reset.
REQ-025 The trigger edge register SHALL reset to 1 so a trigger held high through reset is not accepted.

Configuration
REQ-026 Macro SR04_ECHO_HOLDOFF_EN, when defined, SHALL enable the HOLDOFF state.
- With it: after ECHO the FSM holds HOLDOFF_US ticks, ignoring triggers, then goes to IDLE.
- Without it: ECHO -> IDLE directly; HOLDOFF_US is unused and the HOLDOFF state is absent.

Structure
REQ-027 Package sr04_pkg SHALL hold:
- the state enum;
- US_PER_CM = 58;
- MIN_DIST_CM = 2 and MAX_DIST_CM = 400;
- the counter width (16).
REQ-028 A sub-module sr04_us_timer (16-bit tick counter with clear and terminal-count compare) SHALL be instantiated once and shared by all states.

Verification
REQ-029 The bench SHALL use a 100 MHz clk with i_tick_1us every 100 clk, and cover these scenarios:
- Distance 10 with a 10-tick trigger -> o_echo rises 200 ticks after trigger fall and stays high exactly 580 ticks.
- A 5-tick trigger -> o_short_trig pulses once; o_echo stays 0; o_busy is back to 0 one clk after the fall.
- Distance 0, then 401 -> o_echo high 38000 ticks each time; distance 400 -> 23200 ticks.
- rst for 1 clk at tick 300 of ECHO -> o_echo is 0 at that edge; the next 10-tick trigger gives a full, correct cycle.
- A second trigger during ECHO -> no change to echo width; o_busy stays 1.
- With SR04_ECHO_HOLDOFF_EN, a trigger 1000 ticks after echo fall -> ignored; a trigger after 60000 ticks -> accepted.
